// File: rtl/hacd_axi_line_master.sv
// hacd_axi_line_master: moves one cache line per request as a single AXI4 INCR burst.
// Exactly one line transaction is outstanding; each response is a one-cycle pulse.
module hacd_axi_line_master #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned BEATS  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [BEATS*DATA_W-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic                    rsp_err,
    output logic [BEATS*DATA_W-1:0] rsp_rdata,
    output logic                    axi_awvalid,
    output logic [ADDR_W-1:0]       axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    input  logic                    axi_awready,
    output logic                    axi_wvalid,
    output logic [DATA_W-1:0]       axi_wdata,
    output logic [DATA_W/8-1:0]     axi_wstrb,
    output logic                    axi_wlast,
    input  logic                    axi_wready,
    output logic                    axi_arvalid,
    output logic [ADDR_W-1:0]       axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    input  logic                    axi_arready,
    input  logic                    axi_rvalid,
    input  logic [DATA_W-1:0]       axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    output logic                    axi_rready
);
    localparam int unsigned LINE_B = BEATS * DATA_W / 8;
    localparam int unsigned BW     = $clog2(BEATS) + 1;
    localparam int unsigned IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_B - 1);

    typedef enum logic [2:0] {StIdle, StAw, StW, StAr, StR, StRsp} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              addr_q;
    logic                           write_q;
    logic                           err_q;
    logic [BW-1:0]                  beat_q;
    logic [BEATS-1:0][DATA_W-1:0]   wdata_q;
    logic [BEATS-1:0][DATA_W-1:0]   rdata_q;
    logic [IW-1:0]                  slot;

    assign slot = beat_q[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (req_valid && req_ready) state_d = req_write ? StAw : StAr;
            StAw:   if (axi_awvalid && axi_awready) state_d = StW;
            StW:    if (axi_wvalid && axi_wready && beat_q == LAST_BEAT) state_d = StRsp;
            StAr:   if (axi_arvalid && axi_arready) state_d = StR;
            StR: begin
                if (axi_rvalid && axi_rready && (beat_q == LAST_BEAT || axi_rlast)) begin
                    state_d = StRsp;
                end
            end
            StRsp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Valid/ready outputs are flops loaded from the next state, so none has an input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            req_ready   <= (state_d == StIdle);
            axi_awvalid <= (state_d == StAw);
            axi_wvalid  <= (state_d == StW);
            axi_arvalid <= (state_d == StAr);
            axi_rready  <= (state_d == StR);
            rsp_valid   <= (state_d == StRsp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr & LINE_MASK;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StAw: if (axi_awvalid && axi_awready) beat_q <= '0;
                StAr: if (axi_arvalid && axi_arready) beat_q <= '0;
                StW: begin
                    if (axi_wvalid && axi_wready && beat_q != LAST_BEAT) begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                StR: begin
                    if (axi_rvalid && axi_rready) begin
                        rdata_q[slot] <= axi_rdata;
                        // Early rlast leaves the remaining slots at zero and flags the line.
                        if (axi_rresp != 2'b00 || (axi_rlast && beat_q != LAST_BEAT)) begin
                            err_q <= 1'b1;
                        end
                        if (beat_q != LAST_BEAT) beat_q <= beat_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        axi_awaddr  = addr_q;
        axi_awlen   = 8'(BEATS - 1);
        axi_awsize  = 3'($clog2(DATA_W / 8));
        axi_awburst = 2'b01;
        axi_araddr  = addr_q;
        axi_arlen   = 8'(BEATS - 1);
        axi_arsize  = 3'($clog2(DATA_W / 8));
        axi_arburst = 2'b01;
        axi_wdata   = wdata_q[slot];
        axi_wstrb   = '1;
        axi_wlast   = axi_wvalid && (beat_q == LAST_BEAT);
        rsp_write   = write_q;
        rsp_err     = err_q;
        rsp_rdata   = rdata_q;
    end

endmodule

// File: tb/tb_hacd_axi_line_master.sv
// Bench for hacd_axi_line_master: a table of line transactions against a scripted AXI slave,
// plus stalled-handshake and mid-burst reset sequences.
module tb_hacd_axi_line_master;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_write = 1'b0;
    logic         req_ready;
    logic [63:0]  req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic         rsp_valid, rsp_write, rsp_err;
    logic [511:0] rsp_rdata;
    logic         axi_awvalid, axi_awready = 1'b0;
    logic [63:0]  axi_awaddr, axi_araddr;
    logic [7:0]   axi_awlen, axi_arlen;
    logic [2:0]   axi_awsize, axi_arsize;
    logic [1:0]   axi_awburst, axi_arburst;
    logic         axi_wvalid, axi_wlast, axi_wready = 1'b0;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_arvalid, axi_arready = 1'b0;
    logic         axi_rvalid = 1'b0, axi_rlast = 1'b0, axi_rready;
    logic [255:0] axi_rdata = '0;
    logic [1:0]   axi_rresp = '0;

    hacd_axi_line_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arready(axi_arready),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [63:0]  addr;
        logic [511:0] wd;
        logic [511:0] rd;
        logic [1:0]   rr0;
        logic [1:0]   rr1;
        logic         rl0;
        logic [63:0]  exp_addr;
        logic [511:0] exp_rdata;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic [63:0]  o_addr;
    logic [7:0]   o_len;
    logic [2:0]   o_size;
    logic [1:0]   o_burst;
    logic [255:0] o_w [2];
    logic [1:0]   o_wlast;
    logic         o_rsp_write, o_rsp_err, o_abort_ok, o_timeout;
    logic [511:0] o_rdata;
    int           o_nw, o_lat, o_nrsp, o_unstable, o_early;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Cycle 0 is the cycle in which the request is accepted; the slave answers reads with
    // its first beat two cycles after the cycle carrying the AR handshake.
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [511:0] wd,
                           input logic [511:0] rd, input logic [1:0] rr0, input logic [1:0] rr1,
                           input logic rl0, input int aw_stall, input bit w_toggle,
                           input bit abort);
        int n, aw_wait, aw_hs, ar_hs, ri;
        bit wtog, done, pend_aw, pend_w;
        logic [63:0]  held_aw;
        logic [255:0] held_w;
        o_addr = 'x; o_len = 'x; o_size = 'x; o_burst = 'x; o_wlast = '0;
        o_w[0] = 'x; o_w[1] = 'x; o_rdata = 'x; o_rsp_write = 'x; o_rsp_err = 'x;
        o_nw = 0; o_lat = -1; o_nrsp = 0; o_unstable = 0; o_early = 0;
        o_abort_ok = 1'b0; o_timeout = 1'b0;
        aw_wait = 0; aw_hs = -1; ar_hs = -1; ri = 0;
        wtog = 0; done = 0; pend_aw = 0; pend_w = 0; held_aw = '0; held_w = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            o_timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        for (n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (abort && o_nw >= 1) begin
                rst_n = 1'b0;
                #1;
                o_abort_ok = !(axi_awvalid | axi_wvalid | axi_arvalid | axi_rready |
                               rsp_valid | req_ready);
                axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0; axi_rvalid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (rsp_valid) o_nrsp++;
                end
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    if (rsp_valid) o_nrsp++;
                end
                done = 1;
                break;
            end
            if (pend_aw && axi_awvalid && axi_awaddr !== held_aw) o_unstable++;
            pend_aw = 0;
            axi_awready = 1'b0;
            if (axi_awvalid) begin
                o_addr = axi_awaddr; o_len = axi_awlen; o_size = axi_awsize; o_burst = axi_awburst;
                axi_awready = (aw_wait >= aw_stall);
                aw_wait++;
                if (axi_awready) aw_hs = n;
                else begin
                    pend_aw = 1;
                    held_aw = axi_awaddr;
                end
            end
            if (pend_w && axi_wvalid && axi_wdata !== held_w) o_unstable++;
            pend_w = 0;
            if (w_toggle) wtog = !wtog;
            axi_wready = w_toggle ? wtog : 1'b1;
            if (axi_wvalid) begin
                if (aw_hs < 0 || aw_hs >= n) o_early++;
                if (axi_wready) begin
                    if (o_nw < 2) begin
                        o_w[o_nw] = axi_wdata;
                        o_wlast[o_nw] = axi_wlast;
                    end
                    o_nw++;
                end else begin
                    pend_w = 1;
                    held_w = axi_wdata;
                end
            end
            axi_arready = 1'b1;
            if (axi_arvalid) begin
                o_addr = axi_araddr; o_len = axi_arlen; o_size = axi_arsize; o_burst = axi_arburst;
                ar_hs = n;
            end
            if (ar_hs >= 0 && n >= ar_hs + 2 && ri < 2) begin
                axi_rvalid = 1'b1;
                axi_rdata  = (ri == 0) ? rd[255:0] : rd[511:256];
                axi_rresp  = (ri == 0) ? rr0 : rr1;
                axi_rlast  = (ri == 1) || rl0;
                if (axi_rready) ri++;
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
            end
            if (rsp_valid) begin
                o_nrsp++;
                if (o_nrsp == 1) begin
                    o_lat = n; o_rsp_write = rsp_write; o_rsp_err = rsp_err; o_rdata = rsp_rdata;
                end
            end else if (o_nrsp > 0) begin
                done = 1;
            end
        end
        if (!done) o_timeout = 1'b1;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = '0;
    endtask

    vec_t vecs [7];

    initial begin
        logic [255:0] A, B, C, D;
        A = {8{32'h0A0A_1111}};
        B = {8{32'h0B0B_2222}};
        C = {8{32'h0C0C_3333}};
        D = {8{32'h0D0D_4444}};
        //          wr    addr                    wd      rd      rr0   rr1   rl0
        //          exp_addr                exp_rdata      err  lat
        vecs[0] = '{1'b1, 64'h0000_0000_1000_0047, {B, A}, 512'h0, 2'd0, 2'd0, 1'b0,
                    64'h0000_0000_1000_0040, 512'h0, 1'b0, 4};
        vecs[1] = '{1'b0, 64'h0000_0000_0000_0040, 512'h0, {D, C}, 2'd0, 2'd0, 1'b0,
                    64'h0000_0000_0000_0040, {D, C}, 1'b0, 5};
        vecs[2] = '{1'b0, 64'h1234_5678_9ABC_DEFF, 512'h0, {A, B}, 2'd2, 2'd0, 1'b0,
                    64'h1234_5678_9ABC_DEC0, {A, B}, 1'b1, 5};
        vecs[3] = '{1'b0, 64'h0000_0000_0000_0080, 512'h0, {C, D}, 2'd0, 2'd0, 1'b0,
                    64'h0000_0000_0000_0080, {C, D}, 1'b0, 5};
        vecs[4] = '{1'b0, 64'h0000_0000_0000_0100, 512'h0, {D, C}, 2'd0, 2'd0, 1'b1,
                    64'h0000_0000_0000_0100, {256'h0, C}, 1'b1, 4};
        vecs[5] = '{1'b1, 64'h0000_0000_0000_007F, {A, C}, 512'h0, 2'd0, 2'd0, 1'b0,
                    64'h0000_0000_0000_0040, 512'h0, 1'b0, 4};
        vecs[6] = '{1'b0, 64'h0000_0000_0000_01C0, 512'h0, {B, D}, 2'd0, 2'd3, 1'b0,
                    64'h0000_0000_0000_01C0, {B, D}, 1'b1, 5};

        #12;
        chk("reset req_ready", 512'(req_ready), 512'(0));
        chk("reset valids", 512'({axi_awvalid, axi_wvalid, axi_arvalid, axi_rready, rsp_valid}),
            512'(0));
        chk("reset rsp_err", 512'(rsp_err), 512'(0));
        chk("reset rsp_rdata", rsp_rdata, 512'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", 512'(req_ready), 512'(1));

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].rr0, vecs[i].rr1,
                    vecs[i].rl0, 0, 1'b0, 1'b0);
            chk($sformatf("v%0d timeout", i), 512'(o_timeout), 512'(0));
            chk($sformatf("v%0d addr", i), 512'(o_addr), 512'(vecs[i].exp_addr));
            chk($sformatf("v%0d len/size/burst", i), 512'({o_len, o_size, o_burst}),
                512'({8'd1, 3'd5, 2'd1}));
            chk($sformatf("v%0d rsp count", i), 512'(o_nrsp), 512'(1));
            chk($sformatf("v%0d latency", i), 512'(o_lat), 512'(vecs[i].exp_lat));
            chk($sformatf("v%0d rsp_write", i), 512'(o_rsp_write), 512'(vecs[i].wr));
            chk($sformatf("v%0d rsp_err", i), 512'(o_rsp_err), 512'(vecs[i].exp_err));
            chk($sformatf("v%0d rsp_rdata", i), o_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d w beats", i), 512'(o_nw), 512'(vecs[i].wr ? 2 : 0));
            if (vecs[i].wr) begin
                chk($sformatf("v%0d wdata0", i), 512'(o_w[0]), 512'(vecs[i].wd[255:0]));
                chk($sformatf("v%0d wdata1", i), 512'(o_w[1]), 512'(vecs[i].wd[511:256]));
                chk($sformatf("v%0d wlast", i), 512'(o_wlast), 512'(2'b10));
                chk($sformatf("v%0d early w", i), 512'(o_early), 512'(0));
            end
        end

        // Slow AW, toggling W ready: outputs must hold while stalled.
        run_txn(1'b1, 64'h0000_0000_2000_0013, {D, B}, 512'h0, 2'd0, 2'd0, 1'b0, 4, 1'b1, 1'b0);
        chk("stall timeout", 512'(o_timeout), 512'(0));
        chk("stall addr", 512'(o_addr), 512'(64'h0000_0000_2000_0000));
        chk("stall unstable", 512'(o_unstable), 512'(0));
        chk("stall early w", 512'(o_early), 512'(0));
        chk("stall w beats", 512'(o_nw), 512'(2));
        chk("stall wdata0", 512'(o_w[0]), 512'(B));
        chk("stall wdata1", 512'(o_w[1]), 512'(D));
        chk("stall wlast", 512'(o_wlast), 512'(2'b10));
        chk("stall rsp", 512'({o_nrsp[1:0], o_rsp_write, o_rsp_err}), 512'({2'd1, 1'b1, 1'b0}));

        // Reset after the first write beat abandons the line.
        run_txn(1'b1, 64'h0000_0000_3000_0000, {A, D}, 512'h0, 2'd0, 2'd0, 1'b0, 0, 1'b0, 1'b1);
        chk("abort valids low", 512'(o_abort_ok), 512'(1));
        chk("abort no rsp", 512'(o_nrsp), 512'(0));
        chk("abort rdata cleared", rsp_rdata, 512'h0);
        run_txn(1'b0, 64'h0000_0000_0000_0207, 512'h0, {C, A}, 2'd0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        chk("after abort timeout", 512'(o_timeout), 512'(0));
        chk("after abort addr", 512'(o_addr), 512'(64'h0000_0000_0000_0200));
        chk("after abort rsp", 512'({o_nrsp[1:0], o_rsp_write, o_rsp_err}),
            512'({2'd1, 1'b0, 1'b0}));
        chk("after abort rdata", o_rdata, {C, A});
        chk("after abort latency", 512'(o_lat), 512'(5));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
